// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the data memory responder
package mem_pkg;
    localparam int DATA_W = 24;
    localparam int ADDR_BITS = 10;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);
    localparam int SB_CNT_W = $clog2(SB_DEPTH + 1);
    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_W-1:0]    data;
    } sb_entry_t;
    typedef enum logic [1:0] {PORT_IDLE, PORT_READ, PORT_DRAIN} port_op_t;
endpackage

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of posted stores with youngest-match load lookup
module store_buffer
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  sb_entry_t            push_entry,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 hit,
    output logic [DATA_W-1:0]    hit_data,
    output sb_entry_t            head_entry,
    output logic [SB_CNT_W-1:0]  count,
    output logic                 full,
    output logic                 empty
);
    sb_entry_t             entries [SB_DEPTH];
    logic [SB_PTR_W-1:0]   head;
    logic [SB_PTR_W-1:0]   tail;
    logic [SB_PTR_W-1:0]   idx;

    assign full = count == SB_CNT_W'(SB_DEPTH);
    assign empty = count == '0;
    assign head_entry = entries[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + SB_CNT_W'(push) - SB_CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_entry;
    end

    // walk oldest to youngest so the last match found is the youngest
    always_comb begin
        hit = 1'b0;
        hit_data = '0;
        idx = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + SB_PTR_W'(i);
            if (SB_CNT_W'(i) < count && entries[idx].addr == lookup_addr) begin
                hit = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: scalar data port with posted store buffer, forwarding and 1-cycle loads
module data_memory_responder #(
    parameter int N = mem_pkg::DATA_W,
    parameter int ADDR_BITS = mem_pkg::ADDR_BITS,
    parameter int SB_DEPTH = mem_pkg::SB_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           mem_req,
    input  logic                           MemWrite,
    input  logic [N-1:0]                   address,
    input  logic [N-1:0]                   write_scalar_data,
    output logic                           req_ready,
    output logic [N-1:0]                   read_scalar_data,
    output logic                           read_valid,
    output logic [$clog2(SB_DEPTH+1)-1:0]  sb_count,
    output logic                           busy
);
    import mem_pkg::*;

    logic [N-1:0]         ram [2**ADDR_BITS];
    logic [N-1:0]         dout;
    logic [N-1:0]         fwd_data;
    logic                 fwd_hit;
    logic                 accept;
    logic                 load;
    logic                 store;
    logic                 drain;
    logic                 hit;
    logic                 full;
    logic                 empty;
    logic [N-1:0]         hit_data;
    logic [ADDR_BITS-1:0] word_addr;
    sb_entry_t            head_entry;
    port_op_t             port_op;
    logic                 unused_addr_bits;

    assign word_addr = address[ADDR_BITS-1:0];
    assign unused_addr_bits = ^address[N-1:ADDR_BITS];
    assign req_ready = en & !full;
    assign accept = mem_req & req_ready & !rst;
    assign load = accept & !MemWrite;
    assign store = accept & MemWrite;
    assign drain = en & !rst & !empty & !accept;
    assign busy = sb_count != '0;
    assign read_scalar_data = fwd_hit ? fwd_data : dout;

    store_buffer u_sb (
        .clk        (clk),
        .rst        (rst),
        .push       (store),
        .pop        (drain),
        .push_entry ({word_addr, write_scalar_data}),
        .lookup_addr(word_addr),
        .hit        (hit),
        .hit_data   (hit_data),
        .head_entry (head_entry),
        .count      (sb_count),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        port_op = PORT_IDLE;
        port_op = load & !hit ? PORT_READ : drain ? PORT_DRAIN : PORT_IDLE;
    end

    always_ff @(posedge clk) begin
        if (port_op == PORT_DRAIN) ram[head_entry.addr] <= head_entry.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            read_valid <= 1'b0;
            fwd_hit <= 1'b0;
            fwd_data <= '0;
        end else begin
            read_valid <= load;
            if (port_op == PORT_READ) dout <= ram[word_addr];
            if (load) begin
                fwd_hit <= hit;
                fwd_data <= hit_data;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed stimulus with a scoreboard queue of expected load data
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        mem_req = 1'b0;
    logic        MemWrite = 1'b0;
    logic [23:0] address = '0;
    logic [23:0] write_scalar_data = '0;
    logic        req_ready;
    logic [23:0] read_scalar_data;
    logic        read_valid;
    logic [2:0]  sb_count;
    logic        busy;
    logic [23:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    data_memory_responder dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .mem_req          (mem_req),
        .MemWrite         (MemWrite),
        .address          (address),
        .write_scalar_data(write_scalar_data),
        .req_ready        (req_ready),
        .read_scalar_data (read_scalar_data),
        .read_valid       (read_valid),
        .sb_count         (sb_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every read_valid pulse must match the oldest expected load
    always @(negedge clk) begin
        if (read_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got 0x%06h with no load outstanding", read_scalar_data);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if (read_scalar_data !== e) begin
                    errors++;
                    $display("FAIL load_data: got 0x%06h expected 0x%06h", read_scalar_data, e);
                end
            end
        end
    end

    // called just after a negedge; returns just after the negedge following acceptance
    task automatic req(input logic w, input logic [23:0] a, input logic [23:0] d, input logic [23:0] exp);
        int n;
        n = 0;
        mem_req = 1'b1;
        MemWrite = w;
        address = a;
        write_scalar_data = d;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready stuck at 0 for addr 0x%06h", a);
        end else if (!w) begin
            exp_q.push_back(exp);
        end
        @(negedge clk);
        mem_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout_busy", {23'd0, busy}, 24'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {23'd0, req_ready}, 24'd1);
        chk("rst_read_valid", {23'd0, read_valid}, 24'd0);
        chk("rst_read_data", read_scalar_data, 24'd0);
        chk("rst_sb_count", {21'd0, sb_count}, 24'd0);
        chk("rst_busy", {23'd0, busy}, 24'd0);
        rst = 1'b0;

        req(1'b1, 24'd5, 24'h00ABCD, 24'h0);
        req(1'b0, 24'd5, 24'h0, 24'h00ABCD);
        chk("fwd_sb_count_held", {21'd0, sb_count}, 24'd1);
        @(negedge clk);
        chk("fwd_sb_count_drained", {21'd0, sb_count}, 24'd0);

        req(1'b1, 24'd7, 24'h111111, 24'h0);
        req(1'b1, 24'd7, 24'h222222, 24'h0);
        req(1'b0, 24'd7, 24'h0, 24'h222222);
        wait_idle();

        for (int i = 0; i < 4; i++) req(1'b1, 24'(i), 24'h000100 + 24'(i), 24'h0);
        chk("full_sb_count", {21'd0, sb_count}, 24'd4);
        chk("full_req_ready", {23'd0, req_ready}, 24'd0);
        @(negedge clk);
        chk("stall_sb_count", {21'd0, sb_count}, 24'd3);
        chk("stall_req_ready", {23'd0, req_ready}, 24'd1);
        req(1'b1, 24'd4, 24'h000104, 24'h0);
        chk("fifth_sb_count", {21'd0, sb_count}, 24'd4);
        wait_idle();
        for (int i = 0; i < 5; i++) req(1'b0, 24'(i), 24'h0, 24'h000100 + 24'(i));

        req(1'b1, 24'd9, 24'h0F0F0F, 24'h0);
        wait_idle();
        req(1'b0, 24'd9, 24'h0, 24'h0F0F0F);
        req(1'b0, 24'd1033, 24'h0, 24'h0F0F0F);
        req(1'b0, 24'hFFF009, 24'h0, 24'h0F0F0F);

        req(1'b1, 24'd12, 24'h000001, 24'h0);
        wait_idle();
        req(1'b1, 24'd12, 24'h0000FF, 24'h0);
        chk("pre_rst_sb_count", {21'd0, sb_count}, 24'd1);
        rst = 1'b1;
        mem_req = 1'b1;
        MemWrite = 1'b0;
        address = 24'd12;
        @(negedge clk);
        rst = 1'b0;
        mem_req = 1'b0;
        chk("post_rst_sb_count", {21'd0, sb_count}, 24'd0);
        chk("post_rst_read_valid", {23'd0, read_valid}, 24'd0);
        req(1'b0, 24'd12, 24'h0, 24'h000001);

        en = 1'b0;
        #1;
        chk("en0_req_ready", {23'd0, req_ready}, 24'd0);
        mem_req = 1'b1;
        MemWrite = 1'b0;
        address = 24'd9;
        @(negedge clk);
        chk("en0_read_valid", {23'd0, read_valid}, 24'd0);
        chk("en0_data_hold", read_scalar_data, 24'h000001);
        mem_req = 1'b0;
        en = 1'b1;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 24'(exp_q.size()), 24'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the scalar data port of the 24-bit pipelined processor. It accepts load/store requests (address, write data, write strobe) and returns load data with fixed one-cycle latency. Stores are posted into a small store buffer that drains into a single-port synchronous RAM when the port is idle. Loads that hit a buffered store are forwarded from the buffer.

## Interface
- `N`, 24, data and address width
- `ADDR_BITS`, 10, RAM word-address bits (depth 2^ADDR_BITS words)
- `SB_DEPTH`, 4, store-buffer entries (power of 2, ≥2)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: global enable; 0 freezes all state
- `mem_req` in 1: request valid this cycle
- `MemWrite` in 1: 1 = store, 0 = load
- `address` in N: word address; only `[ADDR_BITS-1:0]` used, upper bits ignored (aliasing)
- `write_scalar_data` in N: store data
- `req_ready` out 1: request accepted when `mem_req & req_ready`
- `read_scalar_data` out N: load data
- `read_valid` out 1: one-cycle pulse, `read_scalar_data` valid
- `sb_count` out $clog2(SB_DEPTH+1): occupied store-buffer entries
- `busy` out 1: `sb_count != 0`

## Operation
- `req_ready = en & !sb_full`. It is independent of `MemWrite`. When the buffer is full, all requests stall.
- Accepted store: the store enqueues `{addr, data}` at the tail. Nothing else happens in that cycle.
- Accepted load:
  - Compare the load address against all valid buffer entries. The youngest match wins, and its data is captured into the forward register with `fwd_hit=1`.
  - Otherwise the load issues a RAM read on the port.
- Drain: when `en & sb_count>0 & !(accepted request)`, the oldest entry is written to RAM and the head advances.
  - A full buffer therefore drains on the next cycle, because no request is accepted while full.
- The RAM port does one operation per cycle, either a load read or a drain write. It never does both.
- Pointers wrap modulo `SB_DEPTH`.
- Enqueue and drain never occur in the same cycle. `sb_count` changes by at most ±1 per cycle.
- `en=0`: no accept, no drain, and no RAM access. `read_valid` is 0 on the next cycle and `read_scalar_data` holds its value.
- Reset:
  - Head, tail and count are zeroed, which discards all buffered stores.
  - `read_valid=0`, `read_scalar_data=0`, `fwd_hit=0`.
  - RAM contents are not cleared.
- Reset mid-operation: pending stores are lost. A load accepted in the reset cycle is dropped and produces no `read_valid`.

## Timing
- Load accepted at edge t: `read_valid=1` during cycle t+1. `read_scalar_data` = forwarded data if `fwd_hit`, else RAM dout. The output mux is selected by the registered `fwd_hit`.
- RAM data returned for a load at t reflects every drain committed at or before edge t-1. Entries still in the buffer at t are covered by forwarding. There is no hazard window.
- Store visibility: a load accepted in the cycle immediately after a store's acceptance sees that store via forwarding.
- Full → stall: if a store makes `sb_count=SB_DEPTH` at edge t, then:
  - `req_ready=0` during cycle t+1 and a drain occurs at edge t+1;
  - `req_ready=1` again in cycle t+2.
- Reset values: `req_ready=1` (with `en=1`), `read_valid=0`, `read_scalar_data=0`, `sb_count=0`, `busy=0`.

## Structure
- Package `mem_pkg`:
  - constants `DATA_W=24`, `ADDR_BITS`, `SB_DEPTH`;
  - `typedef struct packed {logic [ADDR_BITS-1:0] addr; logic [DATA_W-1:0] data;} sb_entry_t`;
  - `typedef enum {PORT_IDLE, PORT_READ, PORT_DRAIN} port_op_t`.
- Sub-module `store_buffer`:
  - circular FIFO of `sb_entry_t` with head/tail/count and full/empty;
  - combinational youngest-match lookup returning `hit` and `data`.
- Top level: request acceptance, RAM-port arbitration (`port_op_t`), inferred synchronous RAM array, forward register and output mux.

## Test plan
- Reset: hold `rst` 2 cycles → `req_ready=1`, `read_valid=0`, `read_scalar_data=0`, `sb_count=0`, `busy=0`.
- Forward: store 0x00ABCD to addr 5, then immediately load addr 5 → `read_valid` one cycle after the load, data 0x00ABCD. `sb_count` stays 1 until the first idle cycle.
- Youngest match: store 0x111111 to addr 7, store 0x222222 to addr 7, then load addr 7 → 0x222222.
- Full stall: 4 back-to-back stores (addrs 0–3) → `sb_count` reaches 4, `req_ready=0` one cycle, `sb_count` 4→3, `req_ready=1`. A fifth store then accepts.
- RAM path: store 0x0F0F0F to addr 9, idle until `busy=0`, load addr 9 → 0x0F0F0F from RAM one cycle later with `fwd_hit=0`. Load addr 9+1024 returns the same value (aliasing).
- Reset mid-op: write 0x000001 to addr 12 and drain it. Store 0x0000FF to addr 12 (buffered), assert `rst` 1 cycle → `sb_count=0`. Load addr 12 → 0x000001.
